// File: rtl/xalu_muldiv.sv
// ---------------------------------------------------------------------------
// xalu_muldiv : multi-cycle multiply/divide unit for the execute stage.
//
// Owns the architectural HI/LO registers and the 32-bit MUL result register.
// MULT/MULTU/MUL take MULT_LATENCY busy cycles; DIV/DIVU use a radix-2
// restoring divider (32 iteration cycles + 1 sign-fix cycle). MTHI/MTLO
// write HI/LO directly on the accepting edge without going busy.
//
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset (also aborts an in-flight op)
//   start      E-stage multiply-family instruction valid this cycle
//   op         0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MUL, 7 none
//   src_a      rs operand (dividend / multiplicand / MTHI-MTLO data)
//   src_b      rt operand (divisor / multiplier)
//   exp_flush  exception flush; cancels a start in the same cycle only
//   busy       operation in flight (to decode-stage stall logic)
//   done       one-cycle pulse after a multi-cycle op completes
//   hi, lo     HI / LO registers
//   mul_result low 32 bits of the last MUL product
// ---------------------------------------------------------------------------
module xalu_muldiv #(
    parameter int MULT_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        exp_flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mul_result
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL      = 2'd1,
        S_DIV_ITER = 2'd2,
        S_DIV_FIX  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] mulres_q, mulres_d;

    // multiplier operands
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        mul_signed_q, mul_signed_d;
    logic        is_mul32_q, is_mul32_d;

    // divider state: quot_q starts as the dividend magnitude and is shifted
    // out MSB-first into the partial remainder while quotient bits shift in.
    logic [31:0] rem_q, rem_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] div_q, div_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d;

    logic [63:0] a_ext, b_ext, product;
    logic [32:0] shifted;
    logic        ge;
    logic        div_signed;

    // Low 64 bits of an unsigned multiply of sign/zero-extended operands equal
    // the two's complement product, so one multiplier serves both flavours.
    assign a_ext   = mul_signed_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign b_ext   = mul_signed_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign product = a_ext * b_ext;

    // Restoring step: the partial remainder is always < divisor, so after the
    // shift it fits in 33 bits and the subtraction result fits in 32.
    assign shifted = {rem_q, quot_q[31]};
    assign ge      = shifted >= {1'b0, div_q};

    assign div_signed = (op == 3'd2);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        hi_d         = hi_q;
        lo_d         = lo_q;
        mulres_d     = mulres_q;
        a_d          = a_q;
        b_d          = b_q;
        mul_signed_d = mul_signed_q;
        is_mul32_d   = is_mul32_q;
        rem_d        = rem_q;
        quot_d       = quot_q;
        div_d        = div_q;
        neg_quot_d   = neg_quot_q;
        neg_rem_d    = neg_rem_q;
        div0_d       = div0_q;

        case (state_q)
            S_IDLE: begin
                if (start && !exp_flush) begin
                    case (op)
                        3'd0, 3'd1, 3'd6: begin
                            a_d          = src_a;
                            b_d          = src_b;
                            mul_signed_d = (op != 3'd1);
                            is_mul32_d   = (op == 3'd6);
                            cnt_d        = 6'(MULT_LATENCY);
                            state_d      = S_MUL;
                        end
                        3'd2, 3'd3: begin
                            neg_quot_d = div_signed & (src_a[31] ^ src_b[31]);
                            neg_rem_d  = div_signed & src_a[31];
                            quot_d     = (div_signed && src_a[31]) ? -src_a : src_a;
                            div_d      = (div_signed && src_b[31]) ? -src_b : src_b;
                            rem_d      = 32'd0;
                            div0_d     = (src_b == 32'd0);
                            cnt_d      = 6'd32;
                            state_d    = S_DIV_ITER;
                        end
                        3'd4:    hi_d = src_a;
                        3'd5:    lo_d = src_a;
                        default: ;  // reserved op: accepted, no effect
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q == 6'd1) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (is_mul32_q)
                        mulres_d = product[31:0];
                    else
                        {hi_d, lo_d} = product;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_DIV_ITER: begin
                if (ge) begin
                    rem_d  = shifted[31:0] - div_q;
                    quot_d = {quot_q[30:0], 1'b1};
                end else begin
                    rem_d  = shifted[31:0];
                    quot_d = {quot_q[30:0], 1'b0};
                end
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1)
                    state_d = S_DIV_FIX;
            end
            S_DIV_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                // divide by zero keeps the architectural HI/LO untouched
                if (!div0_q) begin
                    lo_d = neg_quot_q ? -quot_q : quot_q;
                    hi_d = neg_rem_q  ? -rem_q  : rem_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 6'd0;
            done_q       <= 1'b0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            mulres_q     <= 32'd0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            mul_signed_q <= 1'b0;
            is_mul32_q   <= 1'b0;
            rem_q        <= 32'd0;
            quot_q       <= 32'd0;
            div_q        <= 32'd0;
            neg_quot_q   <= 1'b0;
            neg_rem_q    <= 1'b0;
            div0_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            mulres_q     <= mulres_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mul_signed_q <= mul_signed_d;
            is_mul32_q   <= is_mul32_d;
            rem_q        <= rem_d;
            quot_q       <= quot_d;
            div_q        <= div_d;
            neg_quot_q   <= neg_quot_d;
            neg_rem_q    <= neg_rem_d;
            div0_q       <= div0_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign mul_result = mulres_q;

endmodule

// File: tb/tb_xalu_muldiv.sv
module tb_xalu_muldiv;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        exp_flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mul_result;

    int errors = 0;
    int checks = 0;

    xalu_muldiv #(.MULT_LATENCY(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .exp_flush  (exp_flush),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .mul_result (mul_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Stall logic must never present a start while the unit is busy.
    always @(negedge clk) begin
        if (!reset) begin
            assert (!(start && busy)) else begin
                errors++;
                $error("FAIL start_while_busy: observed=1 expected=0");
            end
        end
    end

    // Called at a negedge with busy low. Issues one op, counts busy cycles,
    // checks done in the first non-busy cycle, then steps one more cycle.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int exp_busy, input logic exp_done,
                         input int flush_at);
        int n;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            exp_flush = (n == flush_at);
            @(negedge clk);
        end
        exp_flush = 1'b0;
        check({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
        check({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        @(negedge clk);
        if (exp_done)
            check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        $display("op %0d a=%h b=%h busy=%0d hi=%h lo=%h mul=%h", o, a, b, n, hi, lo, mul_result);
    endtask

    initial begin
        int dones;
        reset     = 1'b1;
        start     = 1'b0;
        op        = 3'd0;
        src_a     = 32'd0;
        src_b     = 32'd0;
        exp_flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_mul", mul_result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // MULT -3 * 5
        do_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd5, 4, 1'b1, -1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);

        // MULTU max * max
        do_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 1'b1, -1);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        // MUL -7 * 3 leaves HI/LO alone
        do_op("mul", 3'd6, 32'hFFFF_FFF9, 32'd3, 4, 1'b1, -1);
        check("mul_res", mul_result, 32'hFFFF_FFEB);
        check("mul_hi", hi, 32'hFFFF_FFFE);
        check("mul_lo", lo, 32'h0000_0001);

        // DIV -7 / 2
        do_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 33, 1'b1, -1);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU 100 / 7
        do_op("divu", 3'd3, 32'd100, 32'd7, 33, 1'b1, -1);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // signed overflow
        do_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b1, -1);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'd0);

        // MTHI / MTLO then divide by zero
        do_op("mthi", 3'd4, 32'h0000_1234, 32'd0, 0, 1'b0, -1);
        check("mthi_hi", hi, 32'h0000_1234);
        do_op("mtlo", 3'd5, 32'h0000_5678, 32'd0, 0, 1'b0, -1);
        check("mtlo_lo", lo, 32'h0000_5678);
        do_op("div0", 3'd3, 32'd9, 32'd0, 33, 1'b1, -1);
        check("div0_hi", hi, 32'h0000_1234);
        check("div0_lo", lo, 32'h0000_5678);

        // reserved op: no busy, no write
        do_op("rsv", 3'd7, 32'hDEAD_BEEF, 32'd1, 0, 1'b0, -1);
        check("rsv_hi", hi, 32'h0000_1234);
        check("rsv_lo", lo, 32'h0000_5678);

        // start together with exp_flush is discarded
        start     = 1'b1;
        exp_flush = 1'b1;
        op        = 3'd0;
        src_a     = 32'd2;
        src_b     = 32'd3;
        @(negedge clk);
        start     = 1'b0;
        exp_flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        check("flush_done", {31'd0, done}, 32'd0);
        check("flush_hi", hi, 32'h0000_1234);
        check("flush_lo", lo, 32'h0000_5678);
        $display("flushed start: busy=%0d hi=%h lo=%h", busy, hi, lo);

        // exp_flush during a DIV does not disturb it: 100 / -7
        do_op("divflush", 3'd2, 32'd100, 32'hFFFF_FFF9, 33, 1'b1, 5);
        check("divflush_lo", lo, 32'hFFFF_FFF2);
        check("divflush_hi", hi, 32'd2);

        // reset in cycle 10 of a DIV aborts it
        start = 1'b1;
        op    = 3'd3;
        src_a = 32'd1000;
        src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        $display("reset mid-div: busy=%0d hi=%h lo=%h", busy, hi, lo);

        do_op("mtlo2", 3'd5, 32'hA5A5_A5A5, 32'd0, 0, 1'b0, -1);
        check("mtlo2_lo", lo, 32'hA5A5_A5A5);
        check("mtlo2_hi", hi, 32'd0);

        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        check("aborted_no_done", 32'(dones), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
